// File: rtl/io_pkg.sv
// ============================================================================
// Module   : io_pkg
// Brief    : Shared widths and FSM state encoding for the I/O stall controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

  localparam int c_DATA_W = 32;
  localparam int c_SW_W   = 16;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT_IN  = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_DONE     = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// ============================================================================
// Module   : btn_sync_edge
// Brief    : 2-flop synchronizer, optional debounce (IO_STALL_DEBOUNCE_EN) and
//            rising-edge detector producing a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_sync_edge #(
  parameter int DB_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("DB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef IO_STALL_DEBOUNCE_EN
  localparam int                 c_CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES);

  logic [c_CNT_W-1:0] r_cnt;

  // Saturating run-length of high samples; any low sample restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!r_sync2) begin
      r_cnt <= '0;
    end else if (r_cnt != c_CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = (r_cnt == c_CNT_MAX);
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign pulse = w_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/io_stall_ctrl.sv
// ============================================================================
// Module   : io_stall_ctrl
// Brief    : Stalls the PC on I/O instructions until the user confirms; latches
//            switch input and holds display output. Debounce: IO_STALL_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_stall_ctrl
  import io_pkg::*;
#(
  parameter int DATA_W    = c_DATA_W,
  parameter int SW_W      = c_SW_W,
  parameter int DB_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              inputInst,
  input  logic              outputInst,
  input  logic              confirm_btn,
  input  logic [SW_W-1:0]   switches,
  input  logic [DATA_W-1:0] out_data,
  output logic              pc_en,
  output logic              io_we,
  output logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] display,
  output logic              io_wait,
  output logic              halted
);

  state_t            r_state;
  state_t            w_next;
  logic              w_cfm;
  logic              r_from_in;
  logic [SW_W-1:0]   r_sw_s1;
  logic [SW_W-1:0]   r_sw_s2;
  logic [DATA_W-1:0] r_display;
  logic [DATA_W-1:0] r_in_data;

  btn_sync_edge #(
    .DB_CYCLES (DB_CYCLES)
  ) u_cfm (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (confirm_btn),
    .pulse (w_cfm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    pc_en   = 1'b0;
    io_we   = 1'b0;
    io_wait = 1'b0;
    halted  = 1'b0;
    case (r_state)
      ST_RUN: begin
        pc_en = ~halt;
        if (inputInst) begin
          w_next = ST_WAIT_IN;
        end else if (outputInst) begin
          w_next = ST_WAIT_OUT;
        end else if (halt) begin
          w_next = ST_HALT;
        end
      end
      ST_WAIT_IN, ST_WAIT_OUT: begin
        io_wait = 1'b1;
        if (w_cfm) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        pc_en  = 1'b1;
        io_we  = r_from_in;
        w_next = ST_RUN;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // Data registers; the switch bank is synchronized alongside the button so
  // both reach the confirm decision with the same delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_from_in <= 1'b0;
      r_display <= '0;
      r_in_data <= '0;
    end else begin
      r_sw_s1 <= switches;
      r_sw_s2 <= r_sw_s1;
      if (r_state == ST_RUN) begin
        if (inputInst) begin
          r_from_in <= 1'b1;
        end else if (outputInst) begin
          r_from_in <= 1'b0;
          r_display <= out_data;
        end
      end
      if ((r_state == ST_WAIT_IN) && w_cfm) begin
        r_in_data <= DATA_W'(r_sw_s2);
      end
    end
  end

  assign display = r_display;
  assign in_data = r_in_data;

endmodule

`default_nettype wire

// File: tb/tb_io_stall_ctrl.sv
// ============================================================================
// Module   : tb_io_stall_ctrl
// Brief    : Scoreboard bench for io_stall_ctrl (optionally IO_STALL_DEBOUNCE_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_io_stall_ctrl;

  localparam int DATA_W    = 32;
  localparam int SW_W      = 16;
  localparam int DB_CYCLES = 8;
`ifdef IO_STALL_DEBOUNCE_EN
  localparam int c_LAT    = DB_CYCLES + 3;
  localparam int c_N_WE   = 4;
`else
  localparam int c_LAT    = 3;
  localparam int c_N_WE   = 3;
`endif

  logic              clk;
  logic              rst_n;
  logic              halt;
  logic              inputInst;
  logic              outputInst;
  logic              confirm_btn;
  logic [SW_W-1:0]   switches;
  logic [DATA_W-1:0] out_data;
  logic              pc_en;
  logic              io_we;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] display;
  logic              io_wait;
  logic              halted;

  io_stall_ctrl #(
    .DATA_W    (DATA_W),
    .SW_W      (SW_W),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .inputInst   (inputInst),
    .outputInst  (outputInst),
    .confirm_btn (confirm_btn),
    .switches    (switches),
    .out_data    (out_data),
    .pc_en       (pc_en),
    .io_we       (io_we),
    .in_data     (in_data),
    .display     (display),
    .io_wait     (io_wait),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                n_tests = 0;
  int                n_fail  = 0;
  int                n_we    = 0;
  logic [DATA_W-1:0] q_in[$];
  logic [DATA_W-1:0] q_disp[$];
  logic [DATA_W-1:0] r_last_disp = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pc_en && n < 400);
    if (!pc_en) chk("wait_done timeout", 32'(pc_en), 32'd1);
  endtask

  // Write-strobe and display scoreboard
  always @(negedge clk) begin
    if (io_we) begin
      n_we++;
      if (q_in.size() == 0) chk("unexpected io_we", 32'(io_we), 32'd0);
      else                  chk("in_data at io_we", in_data, q_in.pop_front());
    end
    if (display !== r_last_disp) begin
      if (q_disp.size() == 0) chk("unexpected display change", display, r_last_disp);
      else                    chk("display update", display, q_disp.pop_front());
      r_last_disp = display;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; halt = 1'b0; inputInst = 1'b0; outputInst = 1'b0;
    confirm_btn = 1'b0; switches = '0; out_data = '0;
    #2;
    chk("rst pc_en", 32'(pc_en), 32'd1);
    chk("rst io_we", 32'(io_we), 32'd0);
    chk("rst io_wait", 32'(io_wait), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst display", display, 32'd0);
    chk("rst in_data", in_data, 32'd0);
    halt = 1'b1;
    #1;
    chk("rst pc_en with halt", 32'(pc_en), 32'd0);
    halt = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("run pc_en", 32'(pc_en), 32'd1);

    // Input instruction, press at cycle 10
    inputInst = 1'b1; switches = 16'h00A5; q_in.push_back(32'h0000_00A5);
    step();
    inputInst = 1'b0;
    chk("wait_in io_wait", 32'(io_wait), 32'd1);
    chk("wait_in pc_en", 32'(pc_en), 32'd0);
    repeat (9) step();
    chk("wait_in held io_wait", 32'(io_wait), 32'd1);
    confirm_btn = 1'b1;
    wait_done(lat);
    chk("input latency", 32'(lat), 32'(c_LAT));
    chk("done io_we", 32'(io_we), 32'd1);
    chk("done in_data", in_data, 32'h0000_00A5);
    chk("done io_wait", 32'(io_wait), 32'd0);
    step();
    chk("post-done io_we", 32'(io_we), 32'd0);
    chk("post-done pc_en", 32'(pc_en), 32'd1);
    confirm_btn = 1'b0;
    repeat (3) step();

    // Output instruction
    outputInst = 1'b1; out_data = 32'hDEAD_BEEF; q_disp.push_back(32'hDEAD_BEEF);
    step();
    outputInst = 1'b0; out_data = 32'h1234_5678;
    chk("wait_out display", display, 32'hDEAD_BEEF);
    chk("wait_out io_wait", 32'(io_wait), 32'd1);
    chk("wait_out pc_en", 32'(pc_en), 32'd0);
    repeat (5) step();
    chk("wait_out held io_wait", 32'(io_wait), 32'd1);
    confirm_btn = 1'b1;
    wait_done(lat);
    chk("output latency", 32'(lat), 32'(c_LAT));
    chk("out done io_we", 32'(io_we), 32'd0);
    chk("out done display held", display, 32'hDEAD_BEEF);
    chk("out done in_data held", in_data, 32'h0000_00A5);
    step();
    confirm_btn = 1'b0;
    repeat (3) step();

    // Button held across two consecutive input instructions
    inputInst = 1'b1; switches = 16'h1234; q_in.push_back(32'h0000_1234);
    step();
    inputInst = 1'b0;
    confirm_btn = 1'b1;
    wait_done(lat);
    chk("held first in_data", in_data, 32'h0000_1234);
    step();
    inputInst = 1'b1; switches = 16'h0F0F; q_in.push_back(32'h0000_0F0F);
    step();
    inputInst = 1'b0;
    repeat (20) step();
    chk("held second stalls", 32'(io_wait), 32'd1);
    chk("held second in_data", in_data, 32'h0000_1234);
    confirm_btn = 1'b0;
    repeat (3) step();
    chk("released still waiting", 32'(io_wait), 32'd1);
    confirm_btn = 1'b1;
    wait_done(lat);
    chk("repress latency", 32'(lat), 32'(c_LAT));
    chk("repress in_data", in_data, 32'h0000_0F0F);
    step();
    confirm_btn = 1'b0;
    repeat (3) step();

`ifdef IO_STALL_DEBOUNCE_EN
    // Short glitch is rejected; a long press confirms
    inputInst = 1'b1; switches = 16'h00C3; q_in.push_back(32'h0000_00C3);
    step();
    inputInst = 1'b0;
    confirm_btn = 1'b1;
    repeat (5) step();
    confirm_btn = 1'b0;
    repeat (4) step();
    chk("glitch rejected", 32'(io_wait), 32'd1);
    confirm_btn = 1'b1;
    wait_done(lat);
    chk("debounce latency", 32'(lat), 32'(c_LAT));
    chk("debounce in_data", in_data, 32'h0000_00C3);
    step();
    confirm_btn = 1'b0;
    repeat (3) step();
`endif

    // Reset in the middle of an input wait
    inputInst = 1'b1; switches = 16'h5555;
    step();
    inputInst = 1'b0;
    chk("abort wait entered", 32'(io_wait), 32'd1);
    confirm_btn = 1'b1;
    step();
    #2;
    q_disp.push_back(32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort io_wait", 32'(io_wait), 32'd0);
    chk("abort io_we", 32'(io_we), 32'd0);
    chk("abort pc_en", 32'(pc_en), 32'd1);
    chk("abort in_data", in_data, 32'd0);
    step(); step();
    rst_n = 1'b1; confirm_btn = 1'b0;
    step();
    chk("post-abort io_wait", 32'(io_wait), 32'd0);
    chk("post-abort in_data", in_data, 32'd0);
    repeat (5) step();

    // Halt is absorbing
    halt = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      chk("halt pc_en", 32'(pc_en), 32'd0);
      chk("halt halted", 32'(halted), 32'd1);
      confirm_btn = i[2];
      inputInst   = i[3];
      step();
    end
    chk("halt io_wait", 32'(io_wait), 32'd0);

    step();
    chk("io_we pulse count", 32'(n_we), 32'(c_N_WE));
    chk("in_data queue drained", 32'(q_in.size()), 32'd0);
    chk("display queue drained", 32'(q_disp.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
